// File: rtl/pipeline_hazard_ctrl.sv
// XM23 pipeline hazard/stall controller: load-use stall, memory wait with timeout, branch flush, forwarding.
// Optional stall-cycle performance counter enabled by PIPELINE_STALL_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [2:0]  dec_src_a,
    input  logic [2:0]  dec_src_b,
    input  logic        dec_use_a,
    input  logic        dec_use_b,
    input  logic        ex_wb,
    input  logic [2:0]  ex_dst,
    input  logic        ex_is_load,
    input  logic        mem_wb,
    input  logic [2:0]  mem_dst,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic [7:0]  stall_o,
    output logic        flush_o,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_err_o,
    output logic [15:0] stall_cycles_o
);

    // state    | meaning
    // RUN      | normal issue, hazards evaluated
    // LOAD_USE | one-cycle bubble after a load-use stall
    // MEM_WAIT | data access outstanding; branch flush deferred
    // FLUSH    | second cycle of a branch flush
    typedef enum logic [1:0] {RUN, LOAD_USE, MEM_WAIT, FLUSH} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       mem_err;
    logic       wait_active;
    logic       load_use_hz;
    logic [2:0] stall_bits;
    logic       flush;

    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (use_src) begin
            if (ex_wb && ex_dst == src && !ex_is_load)
                sel = 2'd1;
            else if (mem_wb && mem_dst == src)
                sel = 2'd2;
        end
        return sel;
    endfunction

    // Once the counter sits at the timeout the access is released even if the request stays up.
    assign wait_active = mem_req & ~mem_ack & (wait_cnt != TIMEOUT);
    assign load_use_hz = dec_valid & ex_wb & ex_is_load &
                         ((dec_use_a & (ex_dst == dec_src_a)) | (dec_use_b & (ex_dst == dec_src_b)));

    always_comb begin
        state_nxt  = state;
        stall_bits = 3'b000;
        flush      = 1'b0;
        if (wait_active) begin
            stall_bits[1] = 1'b1;
            state_nxt     = MEM_WAIT;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush         = 1'b1;
                        stall_bits[2] = 1'b1;
                        state_nxt     = FLUSH;
                    end else if (load_use_hz) begin
                        stall_bits[0] = 1'b1;
                        state_nxt     = LOAD_USE;
                    end
                end
                LOAD_USE: begin
                    if (branch_taken) begin
                        flush         = 1'b1;
                        stall_bits[2] = 1'b1;
                        state_nxt     = FLUSH;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    flush         = 1'b1;
                    stall_bits[2] = 1'b1;
                    state_nxt     = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign stall_o   = rst ? 8'h00 : {5'b00000, stall_bits};
    assign flush_o   = ~rst & flush;
    assign fwd_a     = rst ? 2'd0 : fwd_sel(dec_use_a, dec_src_a);
    assign fwd_b     = rst ? 2'd0 : fwd_sel(dec_use_b, dec_src_b);
    assign mem_err_o = mem_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!mem_req || mem_ack)
                wait_cnt <= 8'd0;
            else if (wait_active)
                wait_cnt <= wait_cnt + 8'd1;
            if (mem_req && !mem_ack && wait_cnt == TIMEOUT)
                mem_err <= 1'b1;
        end
    end

`ifdef PIPELINE_STALL_PERF_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (|stall_o && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: cycle-by-cycle reference model plus directed literal checks.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_use_a, dec_use_b;
    logic [2:0]  dec_src_a, dec_src_b, ex_dst, mem_dst;
    logic        ex_wb, ex_is_load, mem_wb, mem_req, mem_ack, branch_taken;
    logic [7:0]  stall_o;
    logic        flush_o, mem_err_o;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles_o;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_b(dec_src_b),
        .dec_use_a(dec_use_a), .dec_use_b(dec_use_b),
        .ex_wb(ex_wb), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
        .mem_wb(mem_wb), .mem_dst(mem_dst), .mem_req(mem_req), .mem_ack(mem_ack),
        .branch_taken(branch_taken),
        .stall_o(stall_o), .flush_o(flush_o), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_err_o(mem_err_o), .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int fwd_m(input logic use_src, input logic [2:0] src);
        if (!use_src) return 0;
        if (ex_wb && ex_dst == src && !ex_is_load) return 1;
        if (mem_wb && mem_dst == src) return 2;
        return 0;
    endfunction

    // Reference model: history flags describing what happened on the previous cycle.
    bit m_prev_wait, m_prev_lu, m_flush_first, m_err;
    int m_wcnt, m_perf;

    always @(negedge clk) begin
        bit wait_now, flush_now, lu_now, hz;
        logic [7:0] es;
        int exp_perf;
        if (rst) begin
            chk("rst_stall", 32'(stall_o), 0);
            chk("rst_flush", 32'(flush_o), 0);
            chk("rst_fwd_a", 32'(fwd_a), 0);
            chk("rst_fwd_b", 32'(fwd_b), 0);
            chk("rst_mem_err", 32'(mem_err_o), 0);
            chk("rst_perf", 32'(stall_cycles_o), 0);
            m_prev_wait = 0; m_prev_lu = 0; m_flush_first = 0; m_err = 0;
            m_wcnt = 0; m_perf = 0;
        end else begin
            wait_now  = mem_req && !mem_ack && m_wcnt != TO;
            hz        = dec_valid && ex_wb && ex_is_load &&
                        ((dec_use_a && ex_dst == dec_src_a) || (dec_use_b && ex_dst == dec_src_b));
            flush_now = !wait_now && !m_prev_wait && (m_flush_first || branch_taken);
            lu_now    = !wait_now && !m_prev_wait && !flush_now && !m_prev_lu && hz;
            es        = {5'b0, flush_now, wait_now, lu_now};
`ifdef PIPELINE_STALL_PERF_EN
            exp_perf = m_perf;
`else
            exp_perf = 0;
`endif
            chk("model_stall", 32'(stall_o), 32'(es));
            chk("model_flush", 32'(flush_o), 32'(flush_now));
            chk("model_fwd_a", 32'(fwd_a), 32'(fwd_m(dec_use_a, dec_src_a)));
            chk("model_fwd_b", 32'(fwd_b), 32'(fwd_m(dec_use_b, dec_src_b)));
            chk("model_mem_err", 32'(mem_err_o), 32'(m_err));
            chk("model_perf", 32'(stall_cycles_o), 32'(exp_perf));
            if (mem_req && !mem_ack && m_wcnt == TO) m_err = 1;
            if (!mem_req || mem_ack) m_wcnt = 0;
            else if (wait_now) m_wcnt++;
            m_flush_first = flush_now && !m_flush_first;
            m_prev_wait   = wait_now;
            m_prev_lu     = lu_now;
            if (es != 0 && m_perf < 65535) m_perf++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_use_a = 0; dec_use_b = 0; dec_src_a = 0; dec_src_b = 0;
        ex_wb = 0; ex_dst = 0; ex_is_load = 0; mem_wb = 0; mem_dst = 0;
        mem_req = 0; mem_ack = 0; branch_taken = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        step(); step();
        #1;
        chk("reset_stall", 32'(stall_o), 0);
        rst = 0;
        step();

        // Load-use: one stall cycle, then released while the hazard is still present
        dec_valid = 1; ex_is_load = 1; ex_wb = 1; ex_dst = 3; dec_src_a = 3; dec_use_a = 1;
        #1 chk("lu_first", 32'(stall_o), 32'h01);
        step();
        #1 chk("lu_second", 32'(stall_o), 32'h00);
        step(); idle();
        step();

        // Forwarding priority and unused operand
        ex_wb = 1; ex_dst = 2; mem_wb = 1; mem_dst = 2; dec_src_b = 2; dec_use_b = 1;
        dec_src_a = 2; dec_use_a = 1;
        #1 chk("fwd_b_ex", 32'(fwd_b), 1);
        chk("fwd_a_same_idx", 32'(fwd_a), 1);
        step();
        ex_wb = 0;
        #1 chk("fwd_b_mem", 32'(fwd_b), 2);
        dec_use_b = 0;
        #1 chk("fwd_b_unused", 32'(fwd_b), 0);
        ex_wb = 1; ex_is_load = 1;
        #1 chk("fwd_a_load_skip", 32'(fwd_a), 2);
        step(); idle();
        step();

        // Memory wait acked on cycle 4, FSM back in RUN on cycle 5
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("memwait_stall", 32'(stall_o), 32'h02);
            step();
        end
        mem_ack = 1;
        #1 chk("memwait_ack", 32'(stall_o), 32'h00);
        step();
        mem_req = 0; mem_ack = 0; branch_taken = 1;
        #1 chk("memwait_run_flush", 32'(flush_o), 1);
        chk("memwait_no_err", 32'(mem_err_o), 0);
        step();
        branch_taken = 0;
        #1 chk("flush_second", 32'({flush_o, stall_o}), 32'h104);
        step();
        #1 chk("flush_done", 32'(flush_o), 0);
        step();

        // Timeout: stall for TO wait cycles, then forced release and sticky error
        mem_req = 1;
        for (int i = 0; i < TO; i++) begin
            #1 chk("to_stall", 32'(stall_o[1]), 1);
            step();
        end
        #1 chk("to_release", 32'(stall_o), 0);
        step();
        #1 chk("to_err", 32'(mem_err_o), 1);
        mem_req = 0;
        step(); step(); step();
        #1 chk("to_err_sticky", 32'(mem_err_o), 1);

        // Branch held through a 3-cycle wait: flush deferred until after exit
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bw_no_flush", 32'({flush_o, stall_o}), 32'h002);
            step();
        end
        mem_ack = 1;
        #1 chk("bw_exit", 32'({flush_o, stall_o}), 32'h000);
        step();
        mem_req = 0; mem_ack = 0;
        #1 chk("bw_flush1", 32'({flush_o, stall_o}), 32'h104);
        step();
        branch_taken = 0;
        #1 chk("bw_flush2", 32'({flush_o, stall_o}), 32'h104);
        step();
        #1 chk("bw_flush_end", 32'(flush_o), 0);
        step();

        // Reset in the middle of a flush
        branch_taken = 1;
        #1 chk("rf_flush1", 32'(flush_o), 1);
        step();
        branch_taken = 0;
        #1 chk("rf_flush2", 32'(flush_o), 1);
        rst = 1;
        #1 chk("rf_outputs", 32'({stall_cycles_o, mem_err_o, flush_o, stall_o}), 0);
        step(); step();
        rst = 0;
        step();
        mem_req = 1;
        step(); step(); step();
        mem_ack = 1;
        step();
        idle();
        #1;
`ifdef PIPELINE_STALL_PERF_EN
        chk("perf_after_wait", 32'(stall_cycles_o), 3);
`else
        chk("perf_disabled", 32'(stall_cycles_o), 0);
`endif
        step();

        // Pseudo-random sweep checked by the model
        for (int n = 0; n < 400; n++) begin
            dec_valid    = 1'($urandom_range(0, 1));
            dec_use_a    = 1'($urandom_range(0, 1));
            dec_use_b    = 1'($urandom_range(0, 1));
            dec_src_a    = 3'($urandom_range(0, 3));
            dec_src_b    = 3'($urandom_range(0, 3));
            ex_wb        = 1'($urandom_range(0, 1));
            ex_dst       = 3'($urandom_range(0, 3));
            ex_is_load   = 1'($urandom_range(0, 1));
            mem_wb       = 1'($urandom_range(0, 1));
            mem_dst      = 3'($urandom_range(0, 3));
            mem_req      = ($urandom_range(0, 3) == 0);
            mem_ack      = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
